shift_counter_gen: RTL and testbench
====================================

Name: shift_counter_gen

Overview:
- Parametrised successor to the single-mode Johnson counter.
- Runs as a twisted-ring (Johnson, 2N states) or one-hot ring (N states) counter of NUM_FF flops.
- Adds: count enable, up/down direction, synchronous parallel load, binary state-index decode, terminal-count flag, and illegal-state detection with self-recovery.
- Used as a glitch-free sequencer/phase generator; idx/tc feed downstream control.

Parameters:
- NUM_FF, 4, number of flops N (legal range 2..32).
- IDX_W, $clog2(2*NUM_FF), width of the idx output.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; step only when en=1.
- up  input  1  direction: 1 = up (forward sequence), 0 = down (reverse).
- mode  input  1  0 = Johnson, 1 = one-hot ring.
- load  input  1  synchronous parallel load strobe.
- load_val  input  NUM_FF  value loaded when load=1.
- out  output  NUM_FF  counter state (registered).
- idx  output  IDX_W  binary position of out in the current sequence (combinational from out and mode_q).
- tc  output  1  terminal count: en=1 and next step wraps (combinational).
- err  output  1  one-cycle registered pulse when an illegal state is forced to the seed.

Behaviour:
- Internal register mode_q holds the mode in effect.
- Seed: Johnson = all zeros; ring = MSB set, others zero (100..0).
- Reset (rst=1 at posedge): mode_q<=mode, out<=seed(mode), err<=0. Consequently idx=0 and tc=en&&(wrap condition).
- Johnson up: out <= {~out[0], out[N-1:1]}. Sequence for N=4: 0000,1000,1100,1110,1111,0111,0011,0001, then back to 0000.
- Johnson down: out <= {out[N-2:0], ~out[N-1]} (exact reverse sequence).
- Ring up: out <= {out[0], out[N-1:1]}, giving 1000,0100,0010,0001. Ring down: out <= {out[N-2:0], out[N-1]}.
- Legality:
  - Johnson: out is all zeros, or a run of 1s from the MSB, or a run of 0s from the MSB followed by 1s to the LSB.
  - Ring: exactly one bit set.
- idx:
  - Johnson: p = popcount(out). idx = p if out[N-1]=1 or out=0; otherwise idx = 2N-p.
  - Ring: idx = bit position counted from the MSB (MSB=0).
  - Illegal state: idx=0.
- tc = en & legal & (up ? idx==period-1 : idx==0), where period = 2N (Johnson) or N (ring).
- Priority per posedge, highest first:
  1. rst.
  2. Mode change (mode != mode_q): mode_q<=mode, out<=seed(mode), err<=0.
  3. load: if load_val is legal for mode_q, out<=load_val, err<=0. Otherwise out<=seed(mode_q), err<=1.
  4. Current out illegal: out<=seed(mode_q), err<=1. This applies regardless of en.
  5. en=1: step in direction up, err<=0.
  6. Otherwise hold; err<=0.
- A load applied in the same cycle as en=1 takes precedence; there is no step that cycle.
- Direction may change on any cycle; the next step uses the new up value. There is no dead cycle.
- Latency: one clock from en/load/mode to out. idx and tc follow out combinationally.
- Reset asserted mid-sequence overrides everything. Counting resumes from the seed on the first cycle with rst=0 and en=1.

Test Plan (NUM_FF=4):
- Reset, then Johnson up: rst=1 for 1 cycle, mode=0, up=1, en=1 for 9 cycles -> out 0000,1000,1100,1110,1111,0111,0011,0001,0000; idx 0..7 then 0; tc=1 only while idx=7.
- Down and hold: from 1110 (idx 3), up=0 for 4 cycles -> 1100,1000,0000,0001; tc=1 while at 0000. Then en=0 for 3 cycles -> out holds 0001.
- Ring mode: switch mode to 1 -> next edge out=1000, idx=0. up=1, 5 cycles -> 0100,0010,0001,1000,0100; tc=1 at 0001. Down from 1000 -> 0001.
- Load: Johnson mode, load=1 with load_val=0011 -> out=0011, idx=6, err=0. Load 0101 -> out=0000, err=1 for exactly one cycle. Ring mode, load 0110 -> out=1000, err=1.
- Priority: load=1 and en=1 in the same cycle -> loaded value with no step. rst=1 together with load and a mode change -> seed of the sampled mode, err=0.
- Upset recovery: force out=1010 with en=0 -> next edge out=0000, err pulse. Parameter sweep NUM_FF=2 and 7 -> Johnson period 4/14, ring period 2/7, idx wraps correctly.

Source files
------------

// File: rtl/shift_counter_gen.sv
// Parametrised twisted-ring / one-hot ring counter with direction, load,
// binary position decode, terminal count and illegal-state self-recovery.
module shift_counter_gen #(
    parameter int NUM_FF = 4,
    parameter int IDX_W  = $clog2(2 * NUM_FF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              mode,
    input  logic              load,
    input  logic [NUM_FF-1:0] load_val,
    output logic [NUM_FF-1:0] out,
    output logic [IDX_W-1:0]  idx,
    output logic              tc,
    output logic              err
);
    localparam int unsigned N = NUM_FF;
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(2 * N - 1);
    localparam logic [IDX_W-1:0] LAST_R = IDX_W'(N - 1);

    typedef enum logic {
        JOHNSON = 1'b0,
        RING    = 1'b1
    } mode_e;

    mode_e mode_q;
    logic  legal;

    function automatic logic [NUM_FF-1:0] seed_of(input mode_e m);
        logic [NUM_FF-1:0] s;
        s = '0;
        if (m == RING) s[N-1] = 1'b1;
        return s;
    endfunction

    // Johnson-legal states are exactly those with at most one 0/1 boundary.
    function automatic logic is_legal(input logic [NUM_FF-1:0] v, input mode_e m);
        int unsigned ones;
        int unsigned edges;
        ones  = 0;
        edges = 0;
        for (int unsigned i = 0; i < N; i++) if (v[i]) ones++;
        for (int unsigned i = 1; i < N; i++) if (v[i] != v[i-1]) edges++;
        return (m == RING) ? (ones == 1) : (edges <= 1);
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [NUM_FF-1:0] v, input mode_e m);
        int unsigned ones;
        int unsigned pos;
        ones = 0;
        pos  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) begin
                ones++;
                pos = N - 1 - i;
            end
        end
        if (!is_legal(v, m)) return '0;
        if (m == RING) return IDX_W'(pos);
        if (v[N-1] || ones == 0) return IDX_W'(ones);
        return IDX_W'(2 * N - ones);
    endfunction

    function automatic logic [NUM_FF-1:0] step_of(input logic [NUM_FF-1:0] v, input mode_e m,
                                                  input logic dir);
        if (m == RING) return dir ? {v[0], v[N-1:1]} : {v[N-2:0], v[N-1]};
        return dir ? {~v[0], v[N-1:1]} : {v[N-2:0], ~v[N-1]};
    endfunction

    always_comb begin
        legal = is_legal(out, mode_q);
        idx   = index_of(out, mode_q);
        tc    = en && legal &&
                (up ? (idx == ((mode_q == RING) ? LAST_R : LAST_J)) : (idx == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode_e'(mode);
            out    <= seed_of(mode_e'(mode));
            err    <= 1'b0;
        end else if (mode_e'(mode) != mode_q) begin
            mode_q <= mode_e'(mode);
            out    <= seed_of(mode_e'(mode));
            err    <= 1'b0;
        end else if (load) begin
            if (is_legal(load_val, mode_q)) begin
                out <= load_val;
                err <= 1'b0;
            end else begin
                out <= seed_of(mode_q);
                err <= 1'b1;
            end
        end else if (!legal) begin
            out <= seed_of(mode_q);
            err <= 1'b1;
        end else begin
            if (en) out <= step_of(out, mode_q, up);
            err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench: three widths (4, 2, 7) share one stimulus stream and are
// checked against a sequence-table reference model.
module tb_shift_counter_gen;
    logic        clk = 1'b0;
    logic        rst, en, up, mode, load;
    logic [31:0] load_val;

    logic [3:0] o4;  logic [2:0] i4;  logic t4, e4;
    logic [1:0] o2;  logic [1:0] i2;  logic t2, e2;
    logic [6:0] o7;  logic [3:0] i7;  logic t7, e7;

    always #5 clk = ~clk;

    shift_counter_gen #(.NUM_FF(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val[3:0]), .out(o4), .idx(i4), .tc(t4), .err(e4));
    shift_counter_gen #(.NUM_FF(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val[1:0]), .out(o2), .idx(i2), .tc(t2), .err(e2));
    shift_counter_gen #(.NUM_FF(7)) u7 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val[6:0]), .out(o7), .idx(i7), .tc(t7), .err(e7));

    typedef struct packed {
        logic [2:0][31:0] out;
        logic [2:0][5:0]  idx;
        logic [2:0]       tc;
        logic [2:0]       err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_x;
    int          checks = 0;
    int          errors = 0;
    int          width[3] = '{4, 2, 7};
    logic [31:0] m_out[3];
    bit          m_mode[3];
    bit          m_err[3];
    bit          m_valid = 1'b0;

    logic [31:0] a_out[3], a_idx[3], a_tc[3], a_err[3];
    assign a_out[0] = {28'b0, o4}; assign a_idx[0] = {29'b0, i4};
    assign a_out[1] = {30'b0, o2}; assign a_idx[1] = {30'b0, i2};
    assign a_out[2] = {25'b0, o7}; assign a_idx[2] = {28'b0, i7};
    assign a_tc[0] = {31'b0, t4};  assign a_err[0] = {31'b0, e4};
    assign a_tc[1] = {31'b0, t2};  assign a_err[1] = {31'b0, e2};
    assign a_tc[2] = {31'b0, t7};  assign a_err[2] = {31'b0, e7};

    // Reference: the k-th state of each sequence, built directly from its shape.
    function automatic logic [31:0] seq_val(int n, bit m, int k);
        logic [63:0] v;
        if (m) v = 64'd1 << (n - 1 - k);
        else if (k <= n) v = ((64'd1 << k) - 64'd1) << (n - k);
        else v = (64'd1 << (2 * n - k)) - 64'd1;
        return v[31:0];
    endfunction

    function automatic int period(int n, bit m);
        return m ? n : 2 * n;
    endfunction

    function automatic int find_pos(int n, bit m, logic [31:0] v);
        for (int k = 0; k < period(n, m); k++) if (seq_val(n, m, k) == v) return k;
        return -1;
    endfunction

    function automatic logic [31:0] mask(int n);
        logic [63:0] v;
        v = (64'd1 << n) - 64'd1;
        return v[31:0];
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (N=%0d) at %0t: got %0h, expected %0h",
                     name, width[d], $time, got, want);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit u, input bit md,
                        input bit l, input logic [31:0] v, input bit upset);
        exp_t x;
        int   k, n, p;
        logic [31:0] lv;
        @(posedge clk);
        #2;
        rst = r; en = e; up = u; mode = md; load = l; load_val = v;
        if (upset) begin
            force u4.out = 4'b1010;
            #1;
            release u4.out;
            m_out[0] = 32'hA;
        end
        if (m_valid) begin
            for (int d = 0; d < 3; d++) begin
                n = width[d];
                k = find_pos(n, m_mode[d], m_out[d]);
                p = period(n, m_mode[d]);
                x.out[d] = m_out[d];
                x.idx[d] = (k < 0) ? 6'd0 : 6'(k);
                x.tc[d]  = e && (k >= 0) && (u ? (k == p - 1) : (k == 0));
                x.err[d] = m_err[d];
            end
            sbq.push_back(x);
        end
        for (int d = 0; d < 3; d++) begin
            n  = width[d];
            lv = v & mask(n);
            if (r || (md != m_mode[d])) begin
                m_mode[d] = md;
                m_out[d]  = seq_val(n, md, 0);
                m_err[d]  = 1'b0;
            end else if (l) begin
                if (find_pos(n, m_mode[d], lv) >= 0) begin
                    m_out[d] = lv;
                    m_err[d] = 1'b0;
                end else begin
                    m_out[d] = seq_val(n, m_mode[d], 0);
                    m_err[d] = 1'b1;
                end
            end else if (find_pos(n, m_mode[d], m_out[d]) < 0) begin
                m_out[d] = seq_val(n, m_mode[d], 0);
                m_err[d] = 1'b1;
            end else begin
                p = period(n, m_mode[d]);
                k = find_pos(n, m_mode[d], m_out[d]);
                if (e) m_out[d] = seq_val(n, m_mode[d], u ? (k + 1) % p : (k + p - 1) % p);
                m_err[d] = 1'b0;
            end
        end
        m_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_x = sbq.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk("out", d, a_out[d], mon_x.out[d]);
                chk("idx", d, a_idx[d], 32'(mon_x.idx[d]));
                chk("tc",  d, a_tc[d],  32'(mon_x.tc[d]));
                chk("err", d, a_err[d], 32'(mon_x.err[d]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, e, u, md, l, upset;
        logic [31:0] v;
        rst = 1'b1; en = 1'b0; up = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;

        step(1, 1, 1, 0, 0, 0, 0);
        repeat (11) step(0, 1, 1, 0, 0, 0, 0);
        repeat (4)  step(0, 1, 0, 0, 0, 0, 0);
        repeat (3)  step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        repeat (5)  step(0, 1, 1, 1, 0, 0, 0);
        repeat (2)  step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 32'h3, 0);
        step(0, 0, 1, 0, 1, 32'h5, 0);
        repeat (2)  step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 32'h6, 0);
        step(0, 1, 1, 1, 1, 32'h4, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 32'h3, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        repeat (3)  step(0, 0, 1, 0, 0, 0, 0);

        md = 1'b0;
        for (int c = 0; c < 600; c++) begin
            r     = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) md = ~md;
            l     = ($urandom_range(0, 9) == 0);
            e     = ($urandom_range(0, 9) < 7);
            u     = 1'($urandom_range(0, 1));
            upset = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = (32'd1 << $urandom_range(0, 8)) - 32'd1;
                default: v = 32'd1 << $urandom_range(0, 6);
            endcase
            step(r, e, u, md, l, v, upset);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 0, 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
